// File: rtl/mem_dump_uart_pkg.sv
// rtl/mem_dump_uart_pkg.sv - shared state encodings and UART framing constants for the RAM dump engine
package mem_dump_uart_pkg;

    localparam int UART_BITS           = 10;
    localparam int DEFAULT_HALF_PERIOD = 433;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_FIN,
        ST_DONE,
        ST_DRAIN
    } dump_state_t;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_dump_uart_tx.sv
// rtl/mem_dump_uart_tx.sv - 8N1 byte serializer with valid/ready byte input and shared baud divider
module mem_dump_uart_tx
    import mem_dump_uart_pkg::*;
#(
    parameter int COUNTER_MSB = 9,
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       tx
);

    localparam int                 CW        = COUNTER_MSB + 1;
    localparam logic [CW-1:0]      BIT_LAST  = CW'(2 * HALF_PERIOD + 1);
    localparam logic [CW-1:0]      STOP_LAST = CW'(2 * HALF_PERIOD);
    localparam logic [3:0]         STOP_IDX  = 4'(UART_BITS - 1);

    logic                 active;
    logic [UART_BITS-1:0] frame;
    logic [3:0]           bit_idx;
    logic [CW-1:0]        baud;
    logic                 bit_end;

    // The stop bit is one cycle short here; the idle cycle that follows completes it,
    // so a byte accepted in that cycle starts exactly on the stop-bit boundary.
    assign bit_end = (bit_idx == STOP_IDX) ? (baud == STOP_LAST) : (baud == BIT_LAST);
    assign s_ready = !active;
    assign tx      = active ? frame[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            frame   <= '1;
            bit_idx <= '0;
            baud    <= '0;
        end else if (!active) begin
            if (s_valid) begin
                active  <= 1'b1;
                frame   <= {1'b1, s_data, 1'b0};
                bit_idx <= '0;
                baud    <= '0;
            end
        end else if (bit_end) begin
            baud  <= '0;
            frame <= {1'b1, frame[UART_BITS-1:1]};
            if (bit_idx == STOP_IDX) begin
                active <= 1'b0;
            end else begin
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            baud <= baud + CW'(1);
        end
    end

endmodule

// File: rtl/mem_dump_uart.sv
// rtl/mem_dump_uart.sv - reads a RAM word range and streams it LSB-first over a UART TX line
module mem_dump_uart
    import mem_dump_uart_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int COUNTER_MSB = 9,
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic [ADDR_WIDTH-1:0] wordCount,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memEn,
    input  logic [31:0]           memData,
    output logic                  uartTx,
    output logic                  busy,
    output logic                  done
);

    dump_state_t           state, next_state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH:0]   remaining;
    logic [1:0]            byte_idx;
    logic [31:0]           word_buf;
    logic                  s_valid, s_ready, accept, last_byte, last_word, launch;

    assign accept    = s_valid && s_ready;
    assign last_byte = accept && (byte_idx == 2'd3);
    assign last_word = (remaining == (ADDR_WIDTH + 1)'(1));
    assign launch    = (state == ST_IDLE) && start && !abort;
    assign memAddr   = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (launch) next_state = ST_READ;
            ST_READ:  next_state = ST_WAIT;
            ST_WAIT:  next_state = ST_SEND;
            ST_SEND:  if (last_byte) next_state = last_word ? ST_FIN : ST_READ;
            ST_FIN:   if (s_ready) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            ST_DRAIN: if (s_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        // Abort only stops new bytes; DRAIN lets the frame on the line finish cleanly.
        if (abort && (state inside {ST_READ, ST_WAIT, ST_SEND, ST_FIN})) begin
            next_state = ST_DRAIN;
        end
    end

    always_comb begin
        memEn   = (state == ST_READ);
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        s_valid = (state == ST_SEND) && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
        end else begin
            if (launch) begin
                cur       <= startAddr;
                remaining <= (wordCount == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, wordCount};
            end
            if (state == ST_WAIT) begin
                word_buf <= memData;
                byte_idx <= '0;
            end
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (last_byte && !last_word) begin
                cur       <= cur + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    mem_dump_uart_tx #(
        .COUNTER_MSB (COUNTER_MSB),
        .HALF_PERIOD (HALF_PERIOD)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (word_byte(word_buf, byte_idx)),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .tx      (uartTx)
    );

endmodule

// File: tb/tb_mem_dump_uart.sv
// tb/tb_mem_dump_uart.sv - scoreboard bench for mem_dump_uart with a RAM model and mid-bit UART monitor
module tb_mem_dump_uart;

    localparam int AW    = 8;
    localparam int HP    = 1;
    localparam int BIT   = 2 * (HP + 1);
    localparam int FRAME = 10 * BIT;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] startAddr = '0;
    logic [AW-1:0] wordCount = '0;
    logic [AW-1:0] memAddr;
    logic          memEn;
    logic [31:0]   memData;
    logic          uartTx, busy, done;

    always #5 clk = ~clk;

    mem_dump_uart #(.ADDR_WIDTH(AW), .COUNTER_MSB(9), .HALF_PERIOD(HP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .startAddr (startAddr),
        .wordCount (wordCount),
        .abort     (abort),
        .memAddr   (memAddr),
        .memEn     (memEn),
        .memData   (memData),
        .uartTx    (uartTx),
        .busy      (busy),
        .done      (done)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    always @(posedge clk) rd_q <= memEn ? mem[memAddr] : $urandom;
    assign memData = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  exp_q[$];
    int          addr_q[$];
    int          done_cnt = 0, done_cyc = 0, first_start = -1, last_start = 0;
    int          bytes_seen = 0, mem_pulses = 0, mon_t = 0;
    bit          mon_act = 0;
    logic [7:0]  mon_sh = '0;

    function automatic void chk(string name, longint act, longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial forever begin
        int k;
        logic [7:0] e;
        @(negedge clk);
        if (!rst_n) begin
            mon_act = 0;
        end else if (!mon_act) begin
            if (uartTx == 1'b0) begin
                mon_act = 1; mon_t = 0; last_start = cyc;
                if (first_start < 0) first_start = cyc;
            end
        end else begin
            mon_t++;
            if (mon_t % BIT == BIT / 2) begin
                k = mon_t / BIT;
                if (k >= 1 && k <= 8) mon_sh[k-1] = uartTx;
                if (k == 9) begin
                    if (exp_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL uart_byte: got %02h expected none", mon_sh);
                    end else begin
                        e = exp_q.pop_front();
                        chk("uart_byte_stop", {uartTx, mon_sh}, {1'b1, e});
                    end
                    bytes_seen++;
                    mon_act = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && memEn) begin
            mem_pulses++;
            if (addr_q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL mem_addr: got %0h expected none", memAddr);
            end else begin
                chk("mem_addr", memAddr, addr_q.pop_front());
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic push_words(input int addr, input int nwords, input int nbytes);
        for (int w = 0; w < nwords; w++) begin
            int a;
            a = (addr + w) % DEPTH;
            addr_q.push_back(a);
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < nbytes) exp_q.push_back(8'((mem[a] >> (8 * b)) & 32'hff));
        end
    endtask

    task automatic pulse_start(input int addr, input int cnt, input bit with_abort);
        @(posedge clk); #1;
        start = 1'b1; abort = with_abort; startAddr = AW'(addr); wordCount = AW'(cnt);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; startAddr = AW'($urandom); wordCount = AW'($urandom);
    endtask

    task automatic wait_idle(input int limit, output int fall_cyc);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        fall_cyc = cyc;
        if (i == limit) begin
            compared++; mismatched++;
            $display("FAIL timeout: busy still high after %0d cycles", limit);
            exp_q.delete(); addr_q.delete();
        end
    endtask

    task automatic run_dump(input string name, input int addr, input int cnt);
        int n, fall;
        n = (cnt == 0) ? DEPTH : cnt;
        push_words(addr, n, 4 * n);
        first_start = -1; done_cnt = 0; mem_pulses = 0;
        pulse_start(addr, cnt, 1'b0);
        chk({name, "_busy"}, busy, 1);
        wait_idle(n * 4 * FRAME + 50, fall);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_span"}, done_cyc - first_start, n * 4 * FRAME);
        chk({name, "_mem_pulses"}, mem_pulses, n);
        chk({name, "_left"}, exp_q.size() + addr_q.size(), 0);
    endtask

    initial begin
        int a, fall, ok, cnt_hi, b1_start;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[8'h10] = 32'h12345678;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", uartTx, 1);
        chk("rst_mem_en", memEn, 0);
        chk("rst_mem_addr", memAddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;

        run_dump("one_word", 'h10, 1);
        run_dump("wrap", 'hFE, 3);
        for (int r = 0; r < 3; r++) run_dump("rand", $urandom_range(0, DEPTH - 1), $urandom_range(1, 4));

        // start while busy must not disturb the running dump
        a = $urandom_range(0, DEPTH - 1);
        push_words(a, 2, 8);
        done_cnt = 0;
        pulse_start(a, 2, 1'b0);
        repeat (60) @(posedge clk);
        pulse_start(a ^ 'h55, 7, 1'b0);
        wait_idle(2 * 4 * FRAME + 50, fall);
        chk("busy_start_done", done_cnt, 1);
        chk("busy_start_left", exp_q.size() + addr_q.size(), 0);

        // start together with abort in IDLE
        pulse_start(3, 1, 1'b1);
        cnt_hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || uartTx == 1'b0) cnt_hi++;
        end
        chk("start_abort_idle", cnt_hi, 0);

        // abort while byte 1 of word 0 is on the line
        a = $urandom_range(0, DEPTH - 1);
        push_words(a, 1, 2);
        bytes_seen = 0; done_cnt = 0; ok = 0;
        pulse_start(a, 2, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bytes_seen == 1 && mon_act && mon_t >= BIT) begin ok = 1; break; end
        end
        chk("abort_reach_byte1", ok, 1);
        b1_start = last_start;
        @(posedge clk); #1 abort = 1'b1;
        wait_idle(4 * FRAME, fall);
        abort = 1'b0;
        chk("abort_done", done_cnt, 0);
        chk("abort_left", exp_q.size() + addr_q.size(), 0);
        chk("abort_full_stop", fall >= b1_start + FRAME, 1);
        cnt_hi = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (uartTx == 1'b0 || busy) cnt_hi++;
        end
        chk("abort_quiet", cnt_hi, 0);

        // asynchronous reset in the middle of a low bit
        a = $urandom_range(0, DEPTH - 1);
        push_words(a, 3, 12);
        bytes_seen = 0; ok = 0;
        pulse_start(a, 3, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bytes_seen >= 2 && uartTx == 1'b0) begin ok = 1; break; end
        end
        chk("rst_mid_reach", ok, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", uartTx, 1);
        chk("rst_mid_busy", busy, 0);
        exp_q.delete(); addr_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_dump("after_reset", $urandom_range(0, DEPTH - 1), $urandom_range(1, 3));

        run_dump("full_range", $urandom_range(0, DEPTH - 1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
